// File: rtl/cdc_app_pkg.sv
// Shared definitions for the usb_cdc loopback application: per-channel
// transform modes and the byte transform applied at each FIFO write port.
package cdc_app_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_INC   = 2'b01,
    MODE_LOWER = 2'b10,
    MODE_SWAP  = 2'b11
  } mode_e;

  function automatic logic [7:0] transform(input logic [7:0] b, input mode_e mode);
    logic is_upper;
    logic is_lower;
    logic [7:0] result;
    is_upper = (b >= 8'h41) && (b <= 8'h5A);
    is_lower = (b >= 8'h61) && (b <= 8'h7A);
    result   = b;
    case (mode)
      MODE_PASS:  result = b;
      MODE_INC:   result = b + 8'h01;
      MODE_LOWER: if (is_upper) result = b + 8'h20;
      MODE_SWAP: begin
        if (is_upper)      result = b + 8'h20;
        else if (is_lower) result = b - 8'h20;
      end
      default:    result = b;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/cdc_app_loopback_if.sv
// App-side byte-stream bundle between usb_cdc (master) and the loopback
// application (slave), all channels packed side by side.
interface cdc_app_loopback_if #(
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [8*CHANNELS-1:0]      out_data_i;
  logic [CHANNELS-1:0]        out_valid_i;
  logic [CHANNELS-1:0]        out_ready_o;
  logic [8*CHANNELS-1:0]      in_data_o;
  logic [CHANNELS-1:0]        in_valid_o;
  logic [CHANNELS-1:0]        in_ready_i;
  logic [2*CHANNELS-1:0]      mode_i;
  logic [(AW+1)*CHANNELS-1:0] level_o;

  modport master (
    output out_data_i, out_valid_i, in_ready_i, mode_i,
    input  out_ready_o, in_data_o, in_valid_o, level_o
  );

  modport slave (
    input  out_data_i, out_valid_i, in_ready_i, mode_i,
    output out_ready_o, in_data_o, in_valid_o, level_o
  );

endinterface

// File: rtl/cdc_app_fifo.sv
// Single-clock FIFO with occupancy count; read data comes straight from
// storage so a byte written at one edge is visible in the following cycle.
module cdc_app_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Ready looks only at the current count, so a read in the same cycle as
  // a full FIFO does not open the write port until the next cycle.
  assign wr_ready = !rst_i && (count != FULL_COUNT);
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign wr_en    = wr_valid && wr_ready;
  assign rd_en    = rd_valid && rd_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the cleared count makes stale
  // entries unreachable, and leaving it out lets the array map onto RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cdc_app_loopback.sv
// Multi-channel usb_cdc loopback: each OUT byte is transformed by its
// channel mode, buffered, and returned on the same channel's IN stream.
module cdc_app_loopback
  import cdc_app_pkg::*;
#(
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 16,
  parameter int LED_HOLD = 1600000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  cdc_app_loopback_if.slave bus,
  output logic              led_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (LED_HOLD > 1) ? $clog2(LED_HOLD) : 1;
  localparam logic [LW-1:0] LED_LOAD = LW'(LED_HOLD - 1);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [7:0] wr_byte;

    // Transform at the write port so later mode changes leave queued bytes alone.
    assign wr_byte = transform(bus.out_data_i[8*c +: 8], mode_e'(bus.mode_i[2*c +: 2]));

    cdc_app_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .wr_data  (wr_byte),
      .wr_valid (bus.out_valid_i[c]),
      .wr_ready (bus.out_ready_o[c]),
      .rd_data  (bus.in_data_o[8*c +: 8]),
      .rd_valid (bus.in_valid_o[c]),
      .rd_ready (bus.in_ready_i[c]),
      .count    (bus.level_o[(AW+1)*c +: (AW+1)])
    );
  end

  logic          any_fire;
  logic [LW-1:0] led_cnt;

  assign any_fire = !rst_i &&
                    ((|(bus.out_valid_i & bus.out_ready_o)) ||
                     (|(bus.in_valid_o  & bus.in_ready_i)));

  // Retriggerable hold: each transfer reloads, idle cycles count down to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i)               led_cnt <= '0;
    else if (any_fire)       led_cnt <= LED_LOAD;
    else if (led_cnt != '0)  led_cnt <= led_cnt - 1'b1;
  end

  assign led_o = (led_cnt != '0) || any_fire;

endmodule

// File: tb/tb_cdc_app_loopback.sv
// Directed bench for cdc_app_loopback: stimulus pushes hand-computed bytes
// into per-channel queues, a negedge monitor pops and compares IN traffic.
module tb_cdc_app_loopback;
  import cdc_app_pkg::*;

  localparam int CH       = 3;
  localparam int DEPTH    = 16;
  localparam int LED_HOLD = 8;
  localparam int LW       = 5;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic led_o;

  always #5 clk = ~clk;

  cdc_app_loopback_if #(.CHANNELS(CH), .DEPTH(DEPTH)) bus ();

  cdc_app_loopback #(
    .CHANNELS (CH),
    .DEPTH    (DEPTH),
    .LED_HOLD (LED_HOLD)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus),
    .led_o (led_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int peak0 = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] m_got;
  logic [7:0] m_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input int ch, input logic [7:0] b);
    case (ch)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endfunction

  function automatic int q_size(input int ch);
    case (ch)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] pop_exp(input int ch);
    case (ch)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic logic [LW-1:0] lvl(input int ch);
    return bus.level_o[LW*ch +: LW];
  endfunction

  function automatic logic [7:0] dat(input int ch);
    return bus.in_data_o[8*ch +: 8];
  endfunction

  // Monitor: every IN handshake seen away from the edge is compared in order.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (int'(lvl(0)) > peak0) peak0 = int'(lvl(0));
      for (int c = 0; c < CH; c++) begin
        if (bus.in_valid_o[c] && bus.in_ready_i[c]) begin
          m_got = dat(c);
          if (q_size(c) == 0) begin
            check($sformatf("ch%0d_spurious_byte", c), {24'd0, m_got}, 32'h100);
          end else begin
            m_exp = pop_exp(c);
            check($sformatf("ch%0d_in_data", c), {24'd0, m_got}, {24'd0, m_exp});
          end
        end
      end
    end
  end

  task automatic set_mode(input int ch, input mode_e m);
    bus.mode_i[2*ch +: 2] = m;
  endtask

  task automatic send(input logic [CH-1:0] mask, input logic [8*CH-1:0] data,
                      input logic [8*CH-1:0] exp, output int cycles);
    logic [CH-1:0] pend;
    logic [CH-1:0] acc;
    @(posedge clk); #1;
    pend = mask;
    for (int c = 0; c < CH; c++)
      if (mask[c]) bus.out_data_i[8*c +: 8] = data[8*c +: 8];
    bus.out_valid_i = bus.out_valid_i | mask;
    cycles = 0;
    while (pend != '0 && cycles < 40) begin
      @(negedge clk);
      acc = pend & bus.out_ready_o;
      for (int c = 0; c < CH; c++)
        if (acc[c]) push_exp(c, exp[8*c +: 8]);
      @(posedge clk); #1;
      bus.out_valid_i = bus.out_valid_i & ~acc;
      pend = pend & ~acc;
      cycles++;
    end
    bus.out_valid_i = bus.out_valid_i & ~pend;
    check("send_accepted", {29'd0, mask & ~pend}, {29'd0, mask});
  endtask

  task automatic send1(input int ch, input logic [7:0] b, input logic [7:0] exp);
    logic [8*CH-1:0] d;
    logic [8*CH-1:0] e;
    logic [CH-1:0]   m;
    int cyc;
    d = '0; e = '0; m = '0;
    d[8*ch +: 8] = b;
    e[8*ch +: 8] = exp;
    m[ch] = 1'b1;
    send(m, d, e, cyc);
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    @(posedge clk); #1;
    bus.in_ready_i = '1;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.in_valid_o != '0 && cyc < 100);
    check("drain_in_valid", {29'd0, bus.in_valid_o}, 32'd0);
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);
    check("q2_empty", q2.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [7:0] str_a [8];
  logic [9:0] hist;
  logic [3:0] hist4;
  logic [CH-1:0] seen_ready;
  int cyc;

  initial begin
    bus.out_data_i  = '0;
    bus.out_valid_i = '0;
    bus.in_ready_i  = '0;
    bus.mode_i      = '0;

    // Reset state
    @(negedge clk);
    check("rst_out_ready", {29'd0, bus.out_ready_o}, 32'd0);
    check("rst_in_valid", {29'd0, bus.in_valid_o}, 32'd0);
    check("rst_level", {17'd0, bus.level_o}, 32'd0);
    check("rst_led", {31'd0, led_o}, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_out_ready", {29'd0, bus.out_ready_o}, 32'h7);

    // Mode 00 pass-through with one-cycle latency
    bus.in_ready_i = 3'b111;
    set_mode(0, MODE_PASS);
    peak0 = 0;
    for (int i = 1; i <= 7; i++) begin
      send1(0, 8'(i), 8'(i));
      @(negedge clk);
      check("lat_in_valid", {31'd0, bus.in_valid_o[0]}, 32'd1);
      check("lat_in_data", {24'd0, dat(0)}, i);
    end
    check("pass_peak_level", peak0, 1);

    // Mode 01 increment, mode 10 lowercase, wrap and range edges
    set_mode(0, MODE_INC);
    for (int i = 0; i < 8; i++) send1(0, 8'(8'h31 + i), 8'(8'h32 + i));
    send1(0, 8'hFF, 8'h00);
    set_mode(0, MODE_LOWER);
    for (int i = 0; i < 8; i++) send1(0, 8'(8'h41 + i), 8'(8'h61 + i));
    send1(0, 8'h40, 8'h40);
    send1(0, 8'h5A, 8'h7A);
    send1(0, 8'h5B, 8'h5B);
    send1(0, 8'h61, 8'h61);
    set_mode(0, MODE_SWAP);
    send1(0, 8'h7A, 8'h5A);
    send1(0, 8'h7B, 8'h7B);
    send1(0, 8'h60, 8'h60);
    wait_drain();

    // Full and backpressure
    bus.in_ready_i = 3'b000;
    set_mode(0, MODE_PASS);
    for (int i = 0; i < 16; i++) send1(0, 8'(8'h40 + i), 8'(8'h40 + i));
    @(negedge clk);
    check("full_out_ready", {31'd0, bus.out_ready_o[0]}, 32'd0);
    check("full_level", {27'd0, lvl(0)}, 32'd16);
    @(posedge clk); #1;
    bus.out_data_i[7:0] = 8'h50;
    bus.out_valid_i[0]  = 1'b1;
    seen_ready = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen_ready = seen_ready | bus.out_ready_o;
    end
    check("full_refuses_extra", {31'd0, seen_ready[0]}, 32'd0);
    @(posedge clk); #1;
    bus.in_ready_i[0] = 1'b1;
    @(negedge clk);
    check("full_ready_during_read", {31'd0, bus.out_ready_o[0]}, 32'd0);
    @(posedge clk); #1;
    bus.in_ready_i[0] = 1'b0;
    @(negedge clk);
    check("ready_after_read", {31'd0, bus.out_ready_o[0]}, 32'd1);
    check("level_after_read", {27'd0, lvl(0)}, 32'd15);
    push_exp(0, 8'h50);
    @(posedge clk); #1;
    bus.out_data_i[7:0] = 8'h51;
    bus.in_ready_i[0]   = 1'b1;
    @(negedge clk);
    check("refull_out_ready", {31'd0, bus.out_ready_o[0]}, 32'd0);
    check("refull_level", {27'd0, lvl(0)}, 32'd16);
    @(posedge clk); #1;
    @(negedge clk);
    check("rw_pre_level", {27'd0, lvl(0)}, 32'd15);
    check("rw_pre_ready", {31'd0, bus.out_ready_o[0]}, 32'd1);
    push_exp(0, 8'h51);
    @(posedge clk); #1;
    bus.out_valid_i[0] = 1'b0;
    bus.in_ready_i[0]  = 1'b0;
    @(negedge clk);
    check("rw_level_unchanged", {27'd0, lvl(0)}, 32'd15);
    wait_drain();

    // Channel isolation with modes 00/01/11, ch1 stalled
    set_mode(0, MODE_PASS);
    set_mode(1, MODE_INC);
    set_mode(2, MODE_SWAP);
    bus.in_ready_i = 3'b101;
    send1(1, 8'h31, 8'h32);
    @(negedge clk);
    check("ch1_held_valid", {31'd0, bus.in_valid_o[1]}, 32'd1);
    check("ch1_held_data", {24'd0, dat(1)}, 32'h32);
    send(3'b101, {8'h61, 8'h00, 8'h61}, {8'h41, 8'h00, 8'h61}, cyc);
    check("iso_a_no_stall", cyc, 1);
    send(3'b101, {8'h42, 8'h00, 8'h42}, {8'h62, 8'h00, 8'h42}, cyc);
    check("iso_b_no_stall", cyc, 1);
    @(negedge clk);
    check("ch1_stable_data", {24'd0, dat(1)}, 32'h32);
    check("ch1_level", {27'd0, lvl(1)}, 32'd1);
    check("ch1_out_ready", {31'd0, bus.out_ready_o[1]}, 32'd1);
    wait_drain();

    // Reset mid-operation discards buffered bytes
    bus.in_ready_i = 3'b000;
    for (int c = 0; c < CH; c++) set_mode(c, MODE_PASS);
    for (int i = 0; i < 5; i++) send1(0, 8'(8'h10 + i), 8'(8'h10 + i));
    send1(2, 8'h20, 8'h20);
    @(negedge clk);
    check("pre_rst_level", {27'd0, lvl(0)}, 32'd5);
    q0.delete();
    q2.delete();
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    check("mid_rst_out_ready", {29'd0, bus.out_ready_o}, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("after_rst_in_valid", {29'd0, bus.in_valid_o}, 32'd0);
    check("after_rst_level", {17'd0, bus.level_o}, 32'd0);
    check("after_rst_out_ready", {29'd0, bus.out_ready_o}, 32'h7);
    check("after_rst_led", {31'd0, led_o}, 32'd0);
    @(posedge clk); #1;
    bus.in_ready_i = 3'b111;
    for (int i = 0; i < 12; i++) @(negedge clk);
    check("idle_led_off", {31'd0, led_o}, 32'd0);

    // LED hold, single shot then retrigger
    bus.in_ready_i = 3'b011;
    send1(2, 8'h55, 8'h55);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hist[i] = led_o;
    end
    check("led_single_hold", {22'd0, hist}, 32'h07F);
    send1(2, 8'h56, 8'h56);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hist4[i] = led_o;
    end
    check("led_first_window", {28'd0, hist4}, 32'hF);
    send1(2, 8'h57, 8'h57);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hist[i] = led_o;
    end
    check("led_retrigger_hold", {22'd0, hist}, 32'h07F);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
